delay_tap_reader: RTL and testbench
===================================

// Module: delay_tap_reader
// PURPOSE
// - Read side of the BRAM ring used by the variable-delay FIFO. Once per sample, fetches TAPS
//   samples at independent delays behind the writer's pointer and sums them with per-tap gains.
// - Sits between the delay-line writer (owns wr_ptr and the BRAM write port) and the
//   echo/reverb mixer. Drives the BRAM read port and emits one mixed sample per sample tick.
// PARAMETERS
// - WIDTH   12  sample width, signed two's complement
// - MAXLEN  30  ring depth in samples; AW = $clog2(MAXLEN)
// - TAPS    4   read taps per sample, >= 1
// - GAIN_W  8   unsigned per-tap gain, Q1.(GAIN_W-1); 8'h80 = 1.0
// PORTS
// - clk          in   1              system clock
// - rstn         in   1              synchronous, active-low reset
// - enable       in   1              accept new sample ticks when high
// - sample_tick  in   1              1-cycle pulse, one per audio sample
// - wr_ptr       in   AW             ring address of the newest written sample
// - len          in   TAPS*32        per-tap delay in samples; tap i = len[32*i +: 32]
// - gain         in   TAPS*GAIN_W    per-tap gain; tap i = gain[GAIN_W*i +: GAIN_W]
// - rd_en        out  1              BRAM read strobe
// - rd_addr      out  AW             BRAM read address
// - rd_data      in   WIDTH          BRAM read data, valid the cycle after rd_en
// - out          out  WIDTH          mixed sample, held until the next update
// - out_valid    out  1              1-cycle pulse when out updates
// - busy         out  1              high whenever state != IDLE
// - overrun      out  1              sticky: tick arrived while busy
// BEHAVIOUR
// - Reset, sampled on the clk edge with rstn=0: state=IDLE; out=0; out_valid=0; rd_en=0;
//   rd_addr=0; busy=0; overrun=0; accumulator and tap counter cleared. Reset mid-sample aborts
//   the sample; no out_valid is produced for it.
// - FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE:  sample_tick & enable -> latch wr_ptr, len, gain; clear acc; tap=0; go to ISSUE.
//   ISSUE: rd_en=1, rd_addr=addr(tap); tap++; after tap TAPS-1 go to DRAIN.
//   DRAIN: accumulate the final tap's rd_data; go to DONE.
//   DONE:  out <= scale(acc); out_valid=1 for this cycle; go to IDLE.
// - Accumulate: in every ISSUE cycle after the first, and in DRAIN, acc += $signed(rd_data) *
//   $signed({1'b0, gain_latched[tap-1]}).
// - Timing: tick accepted at cycle 0; taps issued at cycles 1..TAPS; out_valid at cycle TAPS+2.
//   A new tick is accepted no earlier than cycle TAPS+3.
// - Address: L = min(len_i, MAXLEN-1). addr = wr_ptr-L if L <= wr_ptr, else
//   wr_ptr+MAXLEN-L. L=0 reads the newest sample. len is treated as unsigned.
// - Width: acc is WIDTH+GAIN_W+$clog2(TAPS)+1 bits, signed. scale(acc) = acc >>> (GAIN_W-1),
//   arithmetic shift; the result is then reduced to WIDTH bits by the CONFIGURATION rule.
// - A tick while busy is dropped and sets overrun=1. A tick with enable=0 in IDLE is ignored and
//   does not set overrun. Dropping enable mid-sample does not abort the sample.
// - wr_ptr, len and gain changes after the tick is accepted do not affect the sample in progress.
// CONFIGURATION
// - `OUT_SATURATE_EN defined: the scaled result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
// - Not defined: the scaled result is truncated to its low WIDTH bits (two's-complement wrap).
// TESTING (WIDTH=12, MAXLEN=30, TAPS=4, GAIN_W=8; BRAM model, 1-cycle read latency)
// - Ring holds mem[a]=a. wr_ptr=10, len={3,2,1,0}, gain={0,0,0,80h}, one tick
//   -> rd_addr 10,9,8,7 at cycles 1-4; out=10 and out_valid=1 at cycle 6 only.
// - Wrap and clamp: wr_ptr=2, len0=5 -> rd_addr=27. wr_ptr=5, len0=40 -> L=29 -> rd_addr=6.
// - Set every mem to 2047; all gains 80h -> sum 8188. With `OUT_SATURATE_EN: out=2047.
//   Without it: out=12'hFFC (-4).
// - Gain mix: mem=100 everywhere, gains {40h,40h,40h,40h} -> out=200. Gains all 0 -> out=0.
// - Overrun: tick at cycle 0 and again at cycle 3 -> exactly one out_valid (cycle 6); overrun=1
//   and it stays 1 until reset. A tick with enable=0 -> nothing happens, overrun stays 0.
// - Reset: rstn=0 at cycle 3 of a sample -> next cycle busy=0, rd_en=0, out=0, no out_valid.
//   A fresh tick afterwards completes normally.

Source files
------------

// File: rtl/delay_tap_reader_if.sv
// Read port of the delay-line BRAM ring: reader drives the strobe/address, memory returns data.
// Data is valid the cycle after rd_en.
interface delay_tap_reader_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned WIDTH = 12
);
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/delay_tap_reader.sv
// Multi-tap reader for the delay-line BRAM ring: one gained mix of TAPS delayed samples per tick.
// Define OUT_SATURATE_EN to clamp the mixed output; otherwise it wraps to WIDTH bits.
module delay_tap_reader #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned MAXLEN = 30,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned GAIN_W = 8,
    localparam int unsigned AW    = $clog2(MAXLEN)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     sample_tick,
    input  logic [AW-1:0]            wr_ptr,
    input  logic [TAPS*32-1:0]       len,
    input  logic [TAPS*GAIN_W-1:0]   gain,
    delay_tap_reader_if.master       bram,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int unsigned TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned AccW = WIDTH + GAIN_W + $clog2(TAPS) + 1;
    localparam logic signed [AccW-1:0] OutMax = AccW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [AccW-1:0] OutMin = ~OutMax;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                      state_q, state_d;
    logic [TW-1:0]               tap_q, tap_d, gidx;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [TAPS-1:0][31:0]       len_q, len_d;
    logic [TAPS-1:0][GAIN_W-1:0] gain_q, gain_d;
    logic signed [AccW-1:0]      acc_q, acc_d, data_ext, gain_ext, scaled;
    logic [WIDTH-1:0]            out_q, out_d;
    logic                        overrun_q, overrun_d;
    logic                        accept, last_tap, acc_en;

    // Ring address of a tap: clamp the delay to the ring, then step back from the writer.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] ptr, input logic [31:0] dly);
        logic [31:0] l;
        logic [31:0] p;
        l = (dly > MAXLEN - 1) ? 32'(MAXLEN - 1) : dly;
        p = 32'(ptr);
        if (l <= p) return AW'(p - l);
        return AW'(p + MAXLEN - l);
    endfunction

    assign accept   = (state_q == StIdle) && sample_tick && enable;
    assign last_tap = (tap_q == TW'(TAPS - 1));

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: if (last_tap) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        gain_d    = gain_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        out_d     = out_q;
        overrun_d = overrun_q | (sample_tick & (state_q != StIdle));

        // Data arriving now belongs to the tap issued one cycle earlier.
        gidx     = (state_q == StDrain) ? TW'(TAPS - 1) : tap_q - TW'(1);
        data_ext = AccW'($signed(bram.rd_data));
        gain_ext = AccW'({1'b0, gain_q[gidx]});
        acc_en   = ((state_q == StIssue) && (tap_q != '0)) || (state_q == StDrain);
        if (acc_en) acc_d = acc_q + data_ext * gain_ext;

        if (accept) begin
            wr_ptr_d = wr_ptr;
            len_d    = len;
            gain_d   = gain;
            tap_d    = '0;
            acc_d    = '0;
        end
        if (state_q == StIssue) tap_d = tap_q + TW'(1);

        scaled = acc_d >>> (GAIN_W - 1);
        if (state_q == StDrain) begin
`ifdef OUT_SATURATE_EN
            if (scaled > OutMax)      out_d = OutMax[WIDTH-1:0];
            else if (scaled < OutMin) out_d = OutMin[WIDTH-1:0];
            else                      out_d = scaled[WIDTH-1:0];
`else
            out_d = scaled[WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            len_q     <= '0;
            gain_q    <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            gain_q    <= gain_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        bram.rd_en   = 1'b0;
        bram.rd_addr = '0;
        if (state_q == StIssue) begin
            bram.rd_en   = 1'b1;
            bram.rd_addr = tap_addr(wr_ptr_q, len_q[tap_q]);
        end
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out       = out_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_delay_tap_reader.sv
// Bench for delay_tap_reader: per-cycle comparison against a sample-level model, plus
// hand-computed directed cases and a randomized phase.
module tb_delay_tap_reader;
    localparam int WIDTH  = 12;
    localparam int MAXLEN = 30;
    localparam int TAPS   = 4;
    localparam int GAIN_W = 8;
    localparam int AW     = 5;
    localparam int OMAX   = (1 << (WIDTH - 1)) - 1;
    localparam int OMIN   = -(1 << (WIDTH - 1));

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   enable = 1'b0;
    logic                   sample_tick = 1'b0;
    logic [AW-1:0]          wr_ptr = '0;
    logic [TAPS*32-1:0]     len;
    logic [TAPS*GAIN_W-1:0] gain;
    logic [WIDTH-1:0]       out;
    logic                   out_valid, busy, overrun;

    int unsigned            len_a [TAPS];
    logic [GAIN_W-1:0]      gain_a [TAPS];
    logic [WIDTH-1:0]       mem [MAXLEN];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: ph = cycle index within the current sample (0 = idle).
    int ph = 0;
    int m_out = 0;
    int m_next = 0;
    bit m_ovr = 1'b0;
    int m_addr [TAPS];

    delay_tap_reader_if #(.AW(AW), .WIDTH(WIDTH)) bram_if ();

    delay_tap_reader #(
        .WIDTH (WIDTH),
        .MAXLEN(MAXLEN),
        .TAPS  (TAPS),
        .GAIN_W(GAIN_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .sample_tick(sample_tick),
        .wr_ptr     (wr_ptr),
        .len        (len),
        .gain       (gain),
        .bram       (bram_if),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        len  = '0;
        gain = '0;
        for (int i = 0; i < TAPS; i++) begin
            len[32*i +: 32]          = len_a[i];
            gain[GAIN_W*i +: GAIN_W] = gain_a[i];
        end
    end

    always @(posedge clk) begin
        if (bram_if.rd_en) bram_if.rd_data <= mem[bram_if.rd_addr];
    end

    function automatic int addr_of(input int i);
        int l;
        l = (len_a[i] > MAXLEN - 1) ? MAXLEN - 1 : int'(len_a[i]);
        return (int'(wr_ptr) + MAXLEN - l) % MAXLEN;
    endfunction

    function automatic int mix_expected();
        int sum;
        int s;
        sum = 0;
        for (int i = 0; i < TAPS; i++)
            sum += int'($signed(mem[addr_of(i)])) * int'(gain_a[i]);
        s = sum >>> (GAIN_W - 1);
`ifdef OUT_SATURATE_EN
        if (s > OMAX) s = OMAX;
        if (s < OMIN) s = OMIN;
`endif
        return s & ((1 << WIDTH) - 1);
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            ph    <= 0;
            m_out <= 0;
            m_ovr <= 1'b0;
        end else if (ph == 0) begin
            if (sample_tick && enable) begin
                ph     <= 1;
                m_next <= mix_expected();
                for (int i = 0; i < TAPS; i++) m_addr[i] <= addr_of(i);
            end
        end else begin
            if (sample_tick) m_ovr <= 1'b1;
            if (ph == TAPS + 1) m_out <= m_next;
            ph <= (ph == TAPS + 2) ? 0 : ph + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int ea;
            ea = 0;
            if (ph >= 1 && ph <= TAPS) ea = m_addr[ph-1];
            check("busy", int'(busy), int'(ph != 0));
            check("rd_en", int'(bram_if.rd_en), int'(ph >= 1 && ph <= TAPS));
            check("rd_addr", int'(bram_if.rd_addr), ea);
            check("out_valid", int'(out_valid), int'(ph == TAPS + 2));
            check("out", int'(out), m_out);
            check("overrun", int'(overrun), int'(m_ovr));
        end
    end

    task automatic fire(input string tag, input int addr0, input int exp_out);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check({tag, "_addr0"}, int'(bram_if.rd_addr), addr0);
        repeat (5) @(negedge clk);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_out"}, int'(out), exp_out);
        @(negedge clk);
    endtask

    task automatic set_all(input int mval, input logic [GAIN_W-1:0] g);
        for (int a = 0; a < MAXLEN; a++) mem[a] = WIDTH'(mval);
        for (int i = 0; i < TAPS; i++) gain_a[i] = g;
    endtask

    function automatic int unsigned pick_len();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, MAXLEN - 1);
            1:       return MAXLEN - 1;
            2:       return $urandom_range(MAXLEN, 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int a = 0; a < MAXLEN; a++) mem[a] = WIDTH'(a);
        len_a  = '{0, 1, 2, 3};
        gain_a = '{8'h80, 8'h00, 8'h00, 8'h00};
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_out", int'(out), 0);
        check("rst_busy", int'(busy), 0);
        rstn = 1'b1;

        // Basic four-tap walk; inputs change after acceptance and must not matter.
        wr_ptr = 10;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int c = 1; c <= TAPS; c++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            wr_ptr      = 0;
            len_a       = '{7, 7, 7, 7};
            check("t1_rd_addr", int'(bram_if.rd_addr), 11 - c);
        end
        @(negedge clk);
        check("t1_valid_c5", int'(out_valid), 0);
        @(negedge clk);
        check("t1_valid_c6", int'(out_valid), 1);
        check("t1_out", int'(out), 10);
        check("t1_model", m_out, 10);
        @(negedge clk);
        check("t1_valid_c7", int'(out_valid), 0);

        wr_ptr = 2;
        len_a  = '{5, 0, 0, 0};
        fire("wrap", 27, 27);
        wr_ptr = 5;
        len_a  = '{40, 0, 0, 0};
        fire("clamp", 6, 6);

        wr_ptr = 0;
        len_a  = '{0, 1, 2, 3};
        set_all(2047, 8'h80);
`ifdef OUT_SATURATE_EN
        fire("full", 0, 2047);
`else
        fire("full", 0, 12'hFFC);
`endif
        set_all(100, 8'h40);
        fire("mix", 0, 200);
        set_all(100, 8'h00);
        fire("zero_gain", 0, 0);
        set_all(100, 8'h40);

        // Ticks with enable low are ignored entirely.
        @(negedge clk);
        enable      = 1'b0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("en0_busy", int'(busy), 0);
        repeat (6) @(negedge clk);
        check("en0_overrun", int'(overrun), 0);
        enable = 1'b1;

        // Second tick at cycle 3 is dropped; enable drop mid-sample does not abort.
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        enable      = 1'b1;
        check("ovr_set", int'(overrun), 1);
        repeat (2) @(negedge clk);
        check("ovr_valid_c6", int'(out_valid), 1);
        check("ovr_out", int'(out), 200);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("ovr_single_valid", int'(out_valid), 0);
        end
        wr_ptr = 4;
        len_a  = '{0, 0, 0, 0};
        fire("ovr_next", 4, 200);
        check("ovr_sticky", int'(overrun), 1);

        // Reset at cycle 3 aborts the sample.
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rd_en", int'(bram_if.rd_en), 0);
        check("rst_mid_out", int'(out), 0);
        check("rst_mid_overrun", int'(overrun), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_mid_no_valid", int'(out_valid), 0);
        end
        fire("post_rst", 4, 200);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rstn        = ($urandom_range(0, 399) != 0);
            enable      = ($urandom_range(0, 7) != 0);
            sample_tick = ($urandom_range(0, 4) == 0);
            wr_ptr      = AW'($urandom_range(0, MAXLEN - 1));
            for (int i = 0; i < TAPS; i++) begin
                len_a[i]  = pick_len();
                gain_a[i] = GAIN_W'($urandom);
            end
            if (ph == 0 && $urandom_range(0, 3) == 0) begin
                for (int a = 0; a < MAXLEN; a++) begin
                    case ($urandom_range(0, 3))
                        0:       mem[a] = 12'h7FF;
                        1:       mem[a] = 12'h800;
                        default: mem[a] = WIDTH'($urandom);
                    endcase
                end
            end
        end

        @(negedge clk);
        rstn        = 1'b1;
        sample_tick = 1'b0;
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
